// File: rtl/io_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : io_sequencer
// Description : Front-panel sequencing controller. Steps through test modes,
//               latches one or two switch operands, runs a req/ack transfer
//               with the datapath and holds the result (or 8'hEE on timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module io_sequencer #(
  parameter int          NUM_MODES  = 8,
  parameter logic [15:0] UNARY_MASK = 16'h0003,
  parameter int          TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] switch,
  input  logic       up,
  input  logic       left,
  input  logic       right,
  input  logic       confirm,
  output logic [3:0] mode,
  output logic [1:0] state,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       req,
  input  logic       ack,
  input  logic [7:0] result,
  output logic [7:0] result_q,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {
    S_SELECT  = 2'b00,
    S_INPUT_A = 2'b01,
    S_INPUT_B = 2'b10,
    S_RUN     = 2'b11
  } state_t;

  localparam int              CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]      MODE_LAST = 4'(NUM_MODES - 1);

  // Button vector ordered by priority: {confirm, up, right, left}
  logic [3:0] btn_now;
  logic [3:0] btn_lvl_q;
  logic [3:0] btn_prev_q;
  logic [3:0] pulse;
  logic       act_confirm;
  logic       act_up;
  logic       act_right;
  logic       act_left;

  state_t           state_q;
  logic [3:0]       mode_q;
  logic [7:0]       op_a_q;
  logic [7:0]       op_b_q;
  logic             req_q;
  logic [7:0]       result_hold_q;
  logic             done_q;
  logic             error_q;
  logic [CNT_W-1:0] cnt_q;

  assign btn_now = {confirm, up, right, left};
  assign pulse   = btn_lvl_q & ~btn_prev_q;

  // Only the highest-priority pulse of a cycle is acted on
  assign act_confirm = pulse[3];
  assign act_up      = pulse[2] & ~pulse[3];
  assign act_right   = pulse[1] & ~pulse[2] & ~pulse[3];
  assign act_left    = pulse[0] & ~pulse[1] & ~pulse[2] & ~pulse[3];

  // Sample button levels; reset preloads both stages so held buttons stay silent
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_lvl_q  <= btn_now;
      btn_prev_q <= btn_now;
    end else begin
      btn_lvl_q  <= btn_now;
      btn_prev_q <= btn_lvl_q;
    end
  end

  // Phase machine with its registered outputs and the request timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_SELECT;
      mode_q        <= 4'd0;
      op_a_q        <= 8'd0;
      op_b_q        <= 8'd0;
      req_q         <= 1'b0;
      result_hold_q <= 8'd0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        S_SELECT: begin
          if (act_confirm) begin
            state_q <= S_INPUT_A;
          end else if (act_right) begin
            mode_q <= (mode_q == MODE_LAST) ? 4'd0 : mode_q + 4'd1;
          end else if (act_left) begin
            mode_q <= (mode_q == 4'd0) ? MODE_LAST : mode_q - 4'd1;
          end
        end
        S_INPUT_A: begin
          if (act_confirm) begin
            op_a_q <= switch;
            if (UNARY_MASK[mode_q]) begin
              state_q <= S_RUN;
              req_q   <= 1'b1;
              done_q  <= 1'b0;
              error_q <= 1'b0;
              cnt_q   <= '0;
            end else begin
              state_q <= S_INPUT_B;
            end
          end else if (act_up) begin
            state_q <= S_SELECT;
          end
        end
        S_INPUT_B: begin
          if (act_confirm) begin
            op_b_q  <= switch;
            state_q <= S_RUN;
            req_q   <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cnt_q   <= '0;
          end else if (act_up) begin
            state_q <= S_INPUT_A;
          end
        end
        S_RUN: begin
          if (req_q) begin
            // A real acknowledge beats a timeout on the same edge
            if (ack) begin
              result_hold_q <= result;
              req_q         <= 1'b0;
              done_q        <= 1'b1;
            end else if (cnt_q == CNT_LAST) begin
              result_hold_q <= 8'hEE;
              req_q         <= 1'b0;
              done_q        <= 1'b1;
              error_q       <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (act_confirm) begin
            state_q <= S_SELECT;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        default: state_q <= S_SELECT;
      endcase
    end
  end

  assign mode     = mode_q;
  assign state    = state_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign req      = req_q;
  assign result_q = result_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_sequencer
// Description : Scoreboard bench for io_sequencer. A driver applies directed
//               and random panel activity, a reference model predicts the
//               outputs after every edge, and a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_sequencer;

  localparam int          NUM_MODES  = 8;
  localparam logic [15:0] UNARY_MASK = 16'h0003;
  localparam int          TIMEOUT    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       up, left, right, confirm;
  logic       ack;
  logic [7:0] res;
  logic [3:0] mode;
  logic [1:0] state;
  logic [7:0] op_a, op_b, result_q;
  logic       req, done, error;

  io_sequencer #(
    .NUM_MODES (NUM_MODES),
    .UNARY_MASK(UNARY_MASK),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .switch  (sw),
    .up      (up),
    .left    (left),
    .right   (right),
    .confirm (confirm),
    .mode    (mode),
    .state   (state),
    .op_a    (op_a),
    .op_b    (op_b),
    .req     (req),
    .ack     (ack),
    .result  (res),
    .result_q(result_q),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mode;
    logic [1:0] state;
    logic [7:0] a;
    logic [7:0] b;
    logic       req;
    logic [7:0] res;
    logic       done;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // ---------------- reference model (phase-level behaviour) ----------------
  int       m_mode, m_phase, m_a, m_b, m_res, m_wait;
  bit       m_req, m_done, m_err;
  bit [3:0] m_prev, m_pend;   // {confirm, up, right, left}

  task automatic enter_run();
    m_phase = 3; m_req = 1; m_done = 0; m_err = 0; m_wait = 0;
  endtask

  task automatic model_edge(output exp_t e);
    bit [3:0] now;
    int       act;   // 0 none, 1 confirm, 2 up, 3 right, 4 left
    bit       req_before;
    now = {confirm, up, right, left};
    if (rst) begin
      m_mode = 0; m_phase = 0; m_a = 0; m_b = 0; m_res = 0; m_wait = 0;
      m_req = 0; m_done = 0; m_err = 0;
      m_pend = 4'b0;
    end else begin
      act = m_pend[3] ? 1 : m_pend[2] ? 2 : m_pend[1] ? 3 : m_pend[0] ? 4 : 0;
      req_before = m_req;
      if (m_phase == 3 && m_req) begin
        if (ack) begin
          m_res = int'(res); m_req = 0; m_done = 1;
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_res = 'hEE; m_req = 0; m_done = 1; m_err = 1;
          end
        end
      end
      case (m_phase)
        0: begin
          if (act == 1)      m_phase = 1;
          else if (act == 3) m_mode = (m_mode + 1) % NUM_MODES;
          else if (act == 4) m_mode = (m_mode + NUM_MODES - 1) % NUM_MODES;
        end
        1: begin
          if (act == 1) begin
            m_a = int'(sw);
            if (UNARY_MASK[m_mode]) enter_run();
            else                    m_phase = 2;
          end else if (act == 2) m_phase = 0;
        end
        2: begin
          if (act == 1) begin
            m_b = int'(sw);
            enter_run();
          end else if (act == 2) m_phase = 1;
        end
        default: begin
          if (act == 1 && !req_before) begin
            m_phase = 0; m_done = 0; m_err = 0;
          end
        end
      endcase
      m_pend = now & ~m_prev;
    end
    m_prev = now;
    e.mode  = 4'(m_mode);
    e.state = 2'(m_phase);
    e.a     = 8'(m_a);
    e.b     = 8'(m_b);
    e.req   = m_req;
    e.res   = 8'(m_res);
    e.done  = m_done;
    e.err   = m_err;
  endtask

  // ---------------- driver helpers ----------------
  task automatic cyc();
    exp_t e;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {confirm, up, right, left} = b;
  endtask

  task automatic idle(input int n);
    set_btn(4'b0);
    ack = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // b = {confirm, up, right, left}
  task automatic press(input logic [3:0] b, input int hold);
    ack = 1'b0;
    set_btn(b);
    for (int i = 0; i < hold; i++) cyc();
    set_btn(4'b0);
    cyc();
  endtask

  task automatic give_ack(input logic [7:0] r);
    set_btn(4'b0);
    ack = 1'b1; res = r;
    cyc();
    ack = 1'b0;
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, req_v);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mode",     {4'b0, mode},   {4'b0, e.mode});
        chk("state",    {6'b0, state},  {6'b0, e.state});
        chk("op_a",     op_a,           e.a);
        chk("op_b",     op_b,           e.b);
        chk("req",      {7'b0, req},    {7'b0, e.req});
        chk("result_q", result_q,       e.res);
        chk("done",     {7'b0, done},   {7'b0, e.done});
        chk("error",    {7'b0, error},  {7'b0, e.err});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ack_pct;
    rst = 1'b1; sw = 8'h00; ack = 1'b0; res = 8'h00;
    set_btn(4'b1000);                 // confirm held through reset
    for (int i = 0; i < 3; i++) cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    idle(2);

    // Mode selection with wrap and same-cycle priority
    press(4'b0001, 1);                // left: 0 -> 7
    press(4'b0010, 1);                // right: 7 -> 0
    press(4'b0010, 3);                // right held: 0 -> 1
    press(4'b0011, 1);                // left+right: right wins -> 2
    press(4'b0010, 1);                // -> 3

    // Binary mode 3 transaction
    press(4'b1000, 1);                // INPUT_A
    sw = 8'h12; press(4'b1000, 2);
    sw = 8'h34; press(4'b1000, 1);    // RUN
    idle(2);
    give_ack(8'h46);
    idle(2);
    press(4'b1000, 1);                // back to SELECT, result held

    // Unary mode 0
    for (int i = 0; i < 3; i++) press(4'b0001, 1);
    press(4'b1000, 1);
    sw = 8'hA5; press(4'b1000, 1);    // straight to RUN, op_b kept
    press(4'b1000, 1);                // confirm ignored while req high
    give_ack(8'h5A);
    press(4'b1000, 1);

    // Backing out of INPUT_B / INPUT_A
    for (int i = 0; i < 3; i++) press(4'b0010, 1);
    press(4'b1000, 1);
    sw = 8'h77; press(4'b1000, 1);    // INPUT_B
    press(4'b0100, 1);                // up -> INPUT_A
    press(4'b0100, 1);                // up -> SELECT

    // Timeout with no ack
    press(4'b1000, 1); press(4'b1000, 1); press(4'b1000, 1);
    idle(TIMEOUT + 4);
    give_ack(8'h99);                  // late ack ignored
    press(4'b1000, 1);

    // Ack on the timeout edge wins
    press(4'b1000, 1); press(4'b1000, 1);
    sw = 8'h0F; press(4'b1000, 1);    // RUN entered on release edge
    idle(TIMEOUT - 1);
    give_ack(8'hC3);
    idle(2);
    press(4'b1000, 1);

    // Reset mid-RUN, then a stray ack
    press(4'b1000, 1); press(4'b1000, 1); press(4'b1000, 1);
    idle(3);
    rst = 1'b1; cyc(); rst = 1'b0;
    give_ack(8'h11);
    idle(3);

    // Random panel activity
    ack_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) ack_pct = (i / 500) % 3 == 0 ? 0 : ((i / 500) % 3 == 1 ? 5 : 30);
      if ($urandom_range(99) < 15) confirm = ~confirm;
      if ($urandom_range(99) < 15) up      = ~up;
      if ($urandom_range(99) < 15) right   = ~right;
      if ($urandom_range(99) < 15) left    = ~left;
      sw  = 8'($urandom);
      res = 8'($urandom);
      ack = ($urandom_range(99) < ack_pct);
      rst = ($urandom_range(399) == 0);
      cyc();
    end
    rst = 1'b0;
    idle(3);

    repeat (3) @(posedge clk);
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_sequencer.md
# io_sequencer

Front-panel sequencing controller between the debounced buttons/switches and the test datapath. Operators step through test modes, enter one or two 8-bit operands from the switches, and launch the operation. The block drives the datapath over a req/ack handshake and holds the returned result for the lights and 7-segment printer. Its `state` and `mode` outputs feed the printer and the input-phase logic directly.

## Interface
- `NUM_MODES`, 8: number of selectable modes (values 0..NUM_MODES-1, max 16).
- `UNARY_MASK`, 16'h0003: bit m set = mode m takes only operand A.
- `TIMEOUT`, 1000: max cycles `req` may stay high without `ack`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `switch`  in  8  operand value from slide switches.
- `up`, `left`, `right`, `confirm`  in  1 each  debounced button levels.
- `mode`  out  4  selected mode.
- `state`  out  2  phase: 00 SELECT, 01 INPUT_A, 10 INPUT_B, 11 RUN.
- `op_a`, `op_b`  out  8 each  latched operands.
- `req`  out  1  operation request to datapath.
- `ack`  in  1  datapath completion, qualifies `result`.
- `result`  in  8  datapath result.
- `result_q`  out  8  held result, or 8'hEE on timeout.
- `done`  out  1  result valid.
- `error`  out  1  timeout occurred.

## Operation
- Edge detection: one-cycle pulse per 0->1 transition of each button, from a registered previous level.
  - During `rst` the previous-level registers load the live inputs, so a button held through reset gives no pulse.
- Pulse priority when several occur in one cycle: confirm > up > right > left. Only the highest is acted on; the others are dropped.
- SELECT:
  - right: `mode` = (mode+1) mod NUM_MODES, so NUM_MODES-1 wraps to 0.
  - left: `mode` = mode-1, with 0 wrapping to NUM_MODES-1.
  - confirm: go to INPUT_A. up: ignored.
- INPUT_A:
  - confirm: `op_a` <= `switch`. Go to RUN if UNARY_MASK[mode], else go to INPUT_B. `op_b` is unchanged.
  - up: return to SELECT; operands are kept. left/right: ignored.
- INPUT_B:
  - confirm: `op_b` <= `switch`, go to RUN.
  - up: return to INPUT_A. left/right: ignored.
- RUN:
  - On entry: `req`=1, `done`=0, `error`=0, timeout counter cleared.
  - While `req`=1, `ack`=1 sampled: `result_q` <= `result`, `req`=0, `done`=1.
  - While `req`=1 and counter reaches TIMEOUT-1 without `ack`: `req`=0, `error`=1, `result_q`=8'hEE, `done`=1.
  - `ack` while `req`=0 is ignored.
  - confirm while `req`=0: go to SELECT and clear `done`/`error`. `result_q` is held.
  - confirm or up while `req`=1: ignored. up while `req`=0: ignored.
- `mode`, `op_a`, `op_b` change only as listed above.

## Timing
- All outputs are registered. Reset values: `mode`=0, `state`=00, `op_a`=`op_b`=0, `req`=0, `result_q`=0, `done`=0, `error`=0.
- Button latency: a level first sampled high at edge n produces a pulse in cycle n. The resulting state/register update is visible after edge n+1.
- `req` rises on the same edge that `state` becomes 11.
- With `ack` high at edge k, `req`=0 and `done`=1 after edge k. Minimum: `ack` on the first cycle `req` is high gives a one-cycle `req`.
- `ack` and timeout on the same edge: `ack` wins, the real result is latched, and `error`=0.
- Timeout counter counts edges with `req`=1. TIMEOUT=1000 with no `ack` means `req` high for exactly 1000 cycles.
- `rst` asserted mid-RUN: `req` and all outputs return to reset values after that edge. Late `ack` after reset is ignored.
- Held button: exactly one action, regardless of hold length.

## Test plan
- Reset with `confirm` held high, then release -> `state`=00, `mode`=0, no transition; all outputs at reset values.
- In SELECT: left once from mode 0 -> mode 7; right twice -> mode 1; left and right pulsed in the same cycle -> mode 2 (right wins).
- Mode 3 (binary): switch=8'h12 confirm, switch=8'h34 confirm -> op_a=12, op_b=34, `req` rises. `ack` 3 cycles later with result=8'h46 -> result_q=46, done=1, req=0. Confirm -> state=00, done=0, result_q=46.
- Mode 0 (unary): switch=8'hA5 confirm -> state=11 directly, op_b unchanged. In INPUT_B of mode 3, up -> state=01.
- No `ack`, TIMEOUT=16 -> `req` high exactly 16 cycles, then error=1, result_q=EE, done=1. Repeat with `ack` on cycle 16 -> real result, error=0.
- `rst` pulsed while `req`=1, then `ack` pulsed -> req=0, state=00, result_q=0, done=0.
